// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier.
package mult_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StSign,
    StDone
  } mult_state_e;

  // Smallest n with 2**n >= value; used to size the iteration counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH over WIDTH+2 clocks,
// signed operation handled by multiplying magnitudes and negating at the end.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = clog2(WIDTH);

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Next-state, operand capture and one shift-add iteration per CALC cycle.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    prod_d   = prod_q;

    // -(2**(WIDTH-1)) wraps to itself, which is the correct unsigned magnitude.
    a_mag  = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag  = (signed_op && b[WIDTH-1]) ? -b : b;
    accept = start && ((state_q == StIdle) || (state_q == StDone));
    // Extra bit keeps the carry out of the upper-half add.
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    unique case (state_q)
      StIdle: ;
      StCalc: begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d = StSign;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSign: begin
        prod_d  = neg_q ? -acc_q : acc_q;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
    endcase

    if (accept) begin
      state_d  = StCalc;
      mcand_d  = a_mag;
      mplier_d = b_mag;
      neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = CntW'(WIDTH - 1);
    end

    // Status flags are registered from the next state so outputs come straight off flops.
    busy_d = (state_d == StCalc) || (state_d == StSign);
    done_d = (state_d == StDone);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases, start-ignore,
// reset abort and back-to-back random operations against an arithmetic model.
module tb_seq_multiplier;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           signed_op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int             vectors = 0;
  int             miscompares = 0;
  logic [2*W-1:0] prev;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Reference: plain integer multiply, low 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint px, py, p;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'({48'd0, x});
      py = longint'({48'd0, y});
    end
    p = px * py;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start (caller is at a negedge), then scramble operands after the edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    start     = 1'b1;
    a         = x;
    b         = y;
    signed_op = s;
    @(posedge clk);
    #1;
    start     = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    signed_op = 1'($urandom);
  endtask

  // Follow an accepted operation to its done cycle; count edges from the start edge.
  task automatic finish(input string tag, input logic [2*W-1:0] exp, input bit poke);
    int lat;
    bit busy_ok, hold_ok, seen;
    lat     = 41;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    seen    = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (product !== prev) hold_ok = 1'b0;
      if (poke) start = (cyc == 3) || (cyc == 10);
    end
    if (poke) start = 1'b0;
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(W + 2));
    check({tag, " busy_while_running"}, 64'(busy_ok), 64'd1);
    check({tag, " product_held"}, 64'(hold_ok), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " product"}, 64'(product), 64'(exp));
    prev = exp;
  endtask

  initial begin
    bit any_done;
    logic [W-1:0] x, y;
    logic s;

    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    prev      = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(16'hAAAA, 16'hAAAA, 1'b0);
    finish("u_aaaa", 32'h71C638E4, 1'b0);

    // Second launch happens in the done cycle: no idle gap.
    launch(16'd30000, 16'd24672, 1'b0);
    finish("u_30000x24672", 32'h2C1DF200, 1'b0);
    launch(16'd24672, 16'd30000, 1'b0);
    finish("u_24672x30000_b2b", 32'h2C1DF200, 1'b0);

    launch(16'hFFFF, 16'hFFFF, 1'b0);
    finish("u_ffff", 32'hFFFE0001, 1'b0);
    launch(16'hFFFF, 16'hFFFF, 1'b1);
    finish("s_m1xm1", 32'h00000001, 1'b0);
    launch(16'hFFFE, 16'h0003, 1'b1);
    finish("s_m2x3", 32'hFFFFFFFA, 1'b0);
    launch(16'h8000, 16'h8000, 1'b1);
    finish("s_minxmin", 32'h40000000, 1'b0);
    launch(16'h8000, 16'h0001, 1'b1);
    finish("s_minx1", 32'hFFFF8000, 1'b0);

    // Extra start pulses mid-operation must be ignored.
    repeat (2) @(negedge clk);
    launch(16'h1234, 16'h5678, 1'b0);
    finish("poke_ignored", ref_mul(16'h1234, 16'h5678, 1'b0), 1'b1);
    @(negedge clk);
    check("poke idle after", 64'(busy), 64'd0);

    // Abort mid-CALC with reset; no done may follow.
    @(negedge clk);
    launch(16'hBEEF, 16'h1357, 1'b1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort product", 64'(product), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev  = '0;
    any_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) any_done = 1'b1;
    end
    check("abort no done", 64'(any_done), 64'd0);
    launch(16'h0101, 16'h0202, 1'b0);
    finish("after_abort", 32'h00020402, 1'b0);

    // Random operations, mostly back-to-back with occasional idle gaps.
    for (int n = 0; n < 2000; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
      launch(x, y, s);
      finish("random", ref_mul(x, y, s), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
